// File: rtl/imm_extend_pipe.sv
// Immediate sign/zero/upper/branch extender with a two-entry skid-buffered
// valid/ready output stage. Results are extended at accept and stored final.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e             state_q;
  logic [OUT_W-1:0]   out_q;
  logic [OUT_W-1:0]   skid_q;
  logic               valid_q;
  logic               ready_q;

  logic [OUT_W-1:0]   sign_c;
  logic [OUT_W-1:0]   ext_d;
  logic               accept_c;
  logic               xfer_c;

  assign accept_c = valid_i && ready_q;
  assign xfer_c   = valid_q && ready_i;
  assign sign_c   = {{EXT_W{data_i[IN_W-1]}}, data_i};

  // Extension of the offered immediate; only consumed on an accept.
  always_comb begin
    ext_d = sign_c;
    unique case (mode_i)
      2'b00: ext_d = sign_c;
      2'b01: ext_d = {{EXT_W{1'b0}}, data_i};
      2'b10: ext_d = {data_i, {EXT_W{1'b0}}};
      2'b11: ext_d = {sign_c[OUT_W-3:0], 2'b00};
      default: ext_d = sign_c;
    endcase
  end

  // EMPTY/ONE/TWO occupancy FSM; flush shares the reset path but ranks below it.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept_c) begin
            out_q   <= ext_d;
            state_q <= S_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept_c && xfer_c) begin
            out_q <= ext_d;
          end else if (accept_c) begin
            skid_q  <= ext_d;
            state_q <= S_TWO;
            ready_q <= 1'b0;
          end else if (xfer_c) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
          end
        end
        S_TWO: begin
          // No accept possible here since ready_o is low.
          if (xfer_c) begin
            out_q   <= skid_q;
            skid_q  <= '0;
            state_q <= S_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          out_q   <= '0;
          skid_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign data_o  = out_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors plus random traffic.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] data_i;
  logic [1:0]  mode_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .data_i (data_i),
    .mode_i (mode_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .flush_i(flush_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = d[15] ? (32'hFFFF0000 | 32'(d)) : 32'(d);
    case (m)
      2'b00:   return s;
      2'b01:   return 32'(d);
      2'b10:   return 32'(d) << 16;
      default: return s << 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; records expected results for accepted items.
  task automatic cyc(input logic v, input logic [15:0] d, input logic [1:0] m,
                     input logic r, input logic fl, input logic rs);
    valid_i = v; data_i = d; mode_i = m; ready_i = r; flush_i = fl; rst_i = rs;
    @(negedge clk);
    if (rs || fl) exp_q.delete();
    else if (v && ready_o) exp_q.push_back(model(d, m));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every transfer-out and checks stability under stall.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_i || flush_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(valid_o), 32'd1);
        chk("stall_data", data_o, prev_data);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got 0x%08h expected no output", data_o);
        end else begin
          chk("sb_data", data_o, exp_q.pop_front());
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
    end
  end

  logic [15:0] vec_d [4];
  logic [31:0] vec_e [4];

  initial begin
    vec_d[0] = 16'h8000; vec_e[0] = 32'hFFFF8000;
    vec_d[1] = 16'h8000; vec_e[1] = 32'h00008000;
    vec_d[2] = 16'h1234; vec_e[2] = 32'h12340000;
    vec_d[3] = 16'hFFFF; vec_e[3] = 32'hFFFFFFFC;
    valid_i = 0; data_i = '0; mode_i = '0; ready_i = 0; flush_i = 0; rst_i = 1;
    @(posedge clk); #1;
    cyc(1, 16'h5555, 2'b00, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_data", data_o, 32'd0);

    // Four modes, one-cycle latency each, back-to-back with ready_i=1
    for (int i = 0; i < 4; i++) begin
      cyc(1, vec_d[i], 2'(i), 1, 0, 0);
      chk("mode_valid", 32'(valid_o), 32'd1);
      chk($sformatf("mode%0d_data", i), data_o, vec_e[i]);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("drain_valid", 32'(valid_o), 32'd0);

    // Backpressure fill to TWO, then drain in order
    cyc(1, 16'h0001, 2'b00, 0, 0, 0);
    chk("bp1_ready", 32'(ready_o), 32'd1);
    chk("bp1_data", data_o, 32'h00000001);
    cyc(1, 16'h0002, 2'b00, 0, 0, 0);
    chk("bp2_ready", 32'(ready_o), 32'd0);
    chk("bp2_data", data_o, 32'h00000001);
    cyc(1, 16'h0003, 2'b00, 0, 0, 0);
    chk("bp3_ready", 32'(ready_o), 32'd0);
    chk("bp3_data", data_o, 32'h00000001);
    cyc(1, 16'h0003, 2'b00, 1, 0, 0);
    chk("bp4_data", data_o, 32'h00000002);
    chk("bp4_ready", 32'(ready_o), 32'd1);
    cyc(1, 16'h0003, 2'b00, 1, 0, 0);
    chk("bp5_data", data_o, 32'h00000003);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp_empty", 32'(valid_o), 32'd0);

    // Streaming: eight results on eight consecutive cycles
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'(i * 16'h0111), 2'b01, 1, 0, 0);
      chk("stream_ready", 32'(ready_o), 32'd1);
      chk("stream_valid", 32'(valid_o), 32'd1);
      chk("stream_data", data_o, 32'(i * 16'h0111));
    end
    cyc(0, 0, 0, 1, 0, 0);

    // Flush in TWO with an offered item
    cyc(1, 16'h1111, 2'b00, 0, 0, 0);
    cyc(1, 16'h2222, 2'b00, 0, 0, 0);
    chk("pre_flush_ready", 32'(ready_o), 32'd0);
    cyc(1, 16'hAAAA, 2'b00, 1, 1, 0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_data", data_o, 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("post_flush_valid", 32'(valid_o), 32'd0);

    // Reset in TWO, then a fresh accept
    cyc(1, 16'h3333, 2'b00, 0, 0, 0);
    cyc(1, 16'h4444, 2'b00, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    chk("rst2_valid", 32'(valid_o), 32'd0);
    chk("rst2_data", data_o, 32'd0);
    chk("rst2_ready", 32'(ready_o), 32'd1);
    cyc(1, 16'h7FFF, 2'b00, 1, 0, 0);
    chk("rst2_accept_valid", 32'(valid_o), 32'd1);
    chk("rst2_accept_data", data_o, 32'h00007FFF);
    cyc(0, 0, 0, 1, 0, 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 2) != 0), 16'($urandom), 2'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0), 1'b0);
    end
    for (int i = 0; i < 20 && valid_o; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("final_drained", 32'(valid_o), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001: Parameter IN_W, default 16, immediate input width; legal range IN_W >= 2.
REQ-002: Parameter OUT_W, default 32, extended output width; legal range OUT_W >= IN_W + 2.
REQ-003: Clock and reset: one clock; reset is synchronous and active-high.
REQ-004: clk_i  input  1  clock; all state updates on rising edge.
REQ-005: rst_i  input  1  synchronous active-high reset.
REQ-006: data_i  input  IN_W  immediate field to extend.
REQ-007: mode_i  input  2  extension mode, sampled with data_i.
REQ-008: valid_i  input  1  upstream offers data_i/mode_i.
REQ-009: ready_o  output  1  block can accept this cycle.
REQ-010: flush_i  input  1  discard all held results.
REQ-011: data_o  output  OUT_W  extended result.
REQ-012: valid_o  output  1  data_o is valid.
REQ-013: ready_i  input  1  downstream accepts data_o this cycle.

Function
REQ-014: Accept occurs when valid_i && ready_o at a rising edge; transfer-out occurs when valid_o && ready_i at a rising edge.
REQ-015: mode 00 SIGN: data_o = data_i[IN_W-1] replicated into bits OUT_W-1..IN_W, data_i in the low bits.
REQ-016: mode 01 ZERO: upper OUT_W-IN_W bits are 0, data_i in the low bits.
REQ-017: mode 10 UPPER: data_i placed in bits OUT_W-1..OUT_W-IN_W, low bits 0.
REQ-018: mode 11 BRANCH: the SIGN result shifted left by 2, dropping its two MSBs, with bits 1..0 = 0.
REQ-019: Extension is computed at accept; results are stored already extended, so the stored mode does not affect later cycles.
REQ-020: Latency is exactly 1 cycle: an accept at edge N with the output stage empty, or draining at edge N, gives valid_o=1 with the result after edge N.
REQ-021: Storage is 2 entries: an output register (OUT) and a skid register (SKID); state machine EMPTY / ONE / TWO.
REQ-022: ready_o = 1 in EMPTY and ONE, 0 in TWO; it is a function of state only, never of ready_i or valid_i.
REQ-023: Transitions: EMPTY + accept -> ONE.
REQ-024: ONE + accept without transfer-out -> TWO; the new result goes to SKID.
REQ-025: ONE + accept with transfer-out -> ONE; the new result replaces OUT.
REQ-026: ONE + transfer-out without accept -> EMPTY.
REQ-027: TWO + transfer-out -> ONE; SKID moves to OUT. No accept is possible in TWO.
REQ-028: Order is strictly preserved; no result is duplicated or dropped except on flush or reset.
REQ-029: valid_o = 1 in ONE and TWO; data_o always drives OUT.
REQ-030: data_o and valid_o hold stable while valid_o=1 and ready_i=0.
REQ-031: flush_i=1 at an edge -> state EMPTY and OUT/SKID cleared to 0; any accept or transfer-out in that cycle is discarded.
REQ-032: flush_i has priority over every other input except rst_i.
REQ-033: Upstream gives no acceptance credit when flush_i=1, even though ready_o may read 1.
REQ-034: mode_i and data_i are ignored when valid_i=0.

Reset
REQ-035: rst_i=1 at an edge -> state EMPTY, data_o=0, valid_o=0, ready_o=1, SKID=0, regardless of other inputs including flush_i.
REQ-036: Reset asserted mid-operation, in state TWO, discards both entries; the first accept after reset release behaves per REQ-020.
REQ-037: No output is X after the first reset edge.

Verification (IN_W=16, OUT_W=32)
REQ-038: Run modes 00/01/10/11 with data_i=0x8000, 0x8000, 0x1234, 0xFFFF and ready_i=1; each result must appear the cycle after accept as 0xFFFF8000, 0x00008000, 0x12340000, 0xFFFFFFFC respectively.
REQ-039: Hold ready_i=0 and offer 3 SIGN items 0x0001, 0x0002, 0x0003 back-to-back -> the first two are accepted, ready_o=0 from the third cycle on, and data_o holds 0x00000001; raising ready_i then yields 1, 2, 3 in order with no gaps once accepted.
REQ-040: Streaming with ready_i=1 and valid_i=1 for 8 cycles -> 8 results on 8 consecutive cycles, ready_o constantly 1.
REQ-041: In state TWO assert flush_i together with valid_i=1 -> next cycle valid_o=0, data_o=0, ready_o=1, and the offered item is not delivered.
REQ-042: In state TWO assert rst_i together with flush_i=0 and ready_i=1 -> next cycle valid_o=0, data_o=0, ready_o=1; then accept 0x7FFF in SIGN mode -> 0x00007FFF one cycle later.
REQ-043: Random traffic with random ready_i, compared against a reference queue -> no loss, duplication or reordering, and data_o stable under stall.
